// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a combinational word RAM between a fetch port and a load/store port
module mem_port_arbiter #(
   parameter int MEM_BYTES = 128,
   parameter int DATA_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_ack,
   output logic [15:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_ack,
   output logic [15:0] d_rdata,
   output logic        d_err,
   output logic        mem_r_nWb,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   localparam logic [15:0] MAX_ADDR = 16'(MEM_BYTES - 2);
   localparam logic PRIO = (DATA_PRIO != 0);
   state_t      state_q;
   logic        last_data_q, sel_data_q, busy_q, mem_r_nwb_q;
   logic        if_ack_q, if_err_q, d_ack_q, d_err_q;
   logic [15:0] mem_addr_q, mem_wdata_q, if_rdata_q, d_rdata_q;
   logic        win_data, win_bad;
   logic [15:0] win_addr;
   // winner of the current IDLE cycle: data wins alone, on priority, or when fetch had the last grant
   always_comb begin
      win_data = d_req & (~if_req | PRIO | ~last_data_q);
      win_addr = win_data ? d_addr : if_addr;
      win_bad  = win_addr[0] | (win_addr > MAX_ADDR);
   end
   // sequencer: IDLE -> ACCESS -> DONE for a good address, IDLE -> DONE for a bad one
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_data_q <= 1'b1;
         sel_data_q  <= 1'b0;
         busy_q      <= 1'b0;
         mem_r_nwb_q <= 1'b1;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_ack_q    <= 1'b0;
         if_err_q    <= 1'b0;
         d_ack_q     <= 1'b0;
         d_err_q     <= 1'b0;
      end else begin
         if_ack_q <= 1'b0;
         if_err_q <= 1'b0;
         d_ack_q  <= 1'b0;
         d_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (if_req | d_req) begin
                  sel_data_q  <= win_data;
                  last_data_q <= win_data;
                  busy_q      <= 1'b1;
                  if (win_bad) begin
                     state_q  <= DONE;
                     if_ack_q <= ~win_data;
                     if_err_q <= ~win_data;
                     d_ack_q  <= win_data;
                     d_err_q  <= win_data;
                  end else begin
                     state_q     <= ACCESS;
                     mem_addr_q  <= win_addr;
                     mem_r_nwb_q <= ~(win_data & d_we);
                     if (win_data & d_we) mem_wdata_q <= d_wdata;
                  end
               end
            end
            ACCESS: begin
               state_q     <= DONE;
               mem_r_nwb_q <= 1'b1;
               if_ack_q    <= ~sel_data_q;
               d_ack_q     <= sel_data_q;
               if (!sel_data_q) if_rdata_q <= mem_rdata;
               else if (mem_r_nwb_q) d_rdata_q <= mem_rdata;
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
   assign if_ack    = if_ack_q;
   assign if_err    = if_err_q;
   assign if_rdata  = if_rdata_q;
   assign d_ack     = d_ack_q;
   assign d_err     = d_err_q;
   assign d_rdata   = d_rdata_q;
   assign mem_r_nWb = mem_r_nwb_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, corner sequences and random traffic against a RAM shadow model
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst, if_req, d_req, d_we, if_req1, d_req1;
   logic [15:0] if_addr, d_addr, d_wdata;
   logic        if_ack, if_err, d_ack, d_err, mem_r_nWb, busy;
   logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_ack1, if_err1, d_ack1, d_err1, mem_r_nWb1, busy1;
   logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   int n_tests = 0, n_fail = 0;

   mem_port_arbiter #(.MEM_BYTES(128), .DATA_PRIO(0)) u0 (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
      .if_rdata(if_rdata), .if_err(if_err), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .mem_r_nWb(mem_r_nWb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy));

   mem_port_arbiter #(.MEM_BYTES(128), .DATA_PRIO(1)) u1 (
      .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr), .if_ack(if_ack1),
      .if_rdata(if_rdata1), .if_err(if_err1), .d_req(d_req1), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_ack(d_ack1), .d_rdata(d_rdata1), .d_err(d_err1),
      .mem_r_nWb(mem_r_nWb1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .busy(busy1));

   function automatic logic [15:0] init_word(input logic [5:0] i);
      return (i == 0) ? 16'h1201 : (i == 1) ? 16'h1301 : (i == 2) ? 16'h1421 : 16'hA000 + {10'd0, i};
   endfunction

   function automatic bit bad_addr(input logic [15:0] a);
      return a[0] || a > 16'd126;
   endfunction

   // MEM2 stand-in: combinational read, write at the clock edge while r_nWb is low, init on rst
   logic [15:0] ram [64];
   always @(posedge clk) begin
      if (rst) for (int i = 0; i < 64; i++) ram[i] <= init_word(6'(i));
      else if (!mem_r_nWb) ram[mem_addr[6:1]] <= mem_wdata;
   end
   assign mem_rdata  = ram[mem_addr[6:1]];
   assign mem_rdata1 = init_word(mem_addr1[6:1]);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic reset_dut();
      rst = 1'b1; if_req = 0; d_req = 0; if_req1 = 0; d_req1 = 0; d_we = 0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_nwb", mem_r_nWb, 1);
      check("rst_addr", mem_addr, 0);
      check("rst_acks", {if_ack, if_err, d_ack, d_err}, 0);
      check("rst_rdata", {if_rdata, d_rdata}, 0);
      rst = 1'b0;
   endtask

   // one transaction on port p (1 = data), returning results once the DUT is back in IDLE
   task automatic xact(input bit p, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                       output logic [15:0] rdata, output logic err, output int lat, output int low);
      if (p) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
      else begin if_req = 1; if_addr = addr; d_we = we; end
      lat = 0; low = 0; rdata = '0; err = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (!mem_r_nWb) begin
            low++;
            check("wr_addr", mem_addr, addr);
            check("wr_data", mem_wdata, wdata);
         end
         if (p ? d_ack : if_ack) begin
            lat = c; rdata = p ? d_rdata : if_rdata; err = p ? d_err : if_err;
            break;
         end
      end
      if_req = 0; d_req = 0;
      tick();
   endtask

   typedef struct {
      bit p; bit we; logic [15:0] addr; logic [15:0] wdata; bit err; logic [15:0] rdata;
   } vec_t;
   vec_t tv [13];

   logic [15:0] rd, shadow [64], paddr [2], pwdata, prev_addr, exp_if, exp_d;
   logic        er, pwe, prev_nwb;
   int          lat, low, low_c, k, prev_c, d1cnt, if1cnt;
   int          wait_c [2];
   bit          pend [2];
   string       seq;

   function automatic logic [15:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      return (r <= 5) ? 16'(2 * $urandom_range(0, 15)) : (r == 6) ? 16'(2 * $urandom_range(0, 15) + 1) :
             (r == 7) ? 16'd126 : (r == 8) ? 16'd128 : 16'hFFFE;
   endfunction

   task automatic start(input int p);
      pend[p] = 1; wait_c[p] = 0; paddr[p] = rand_addr();
      if (p == 1) begin
         pwe = 1'($urandom_range(0, 1)); pwdata = 16'($urandom); low_c = 0;
         d_req = 1; d_we = pwe; d_addr = paddr[1]; d_wdata = pwdata;
      end else begin
         if_req = 1; if_addr = paddr[0];
      end
   endtask

   initial begin
      tv[0]  = '{1, 1, 16'd102, 16'h0003, 0, 16'h0};
      tv[1]  = '{1, 0, 16'd102, 16'h0,    0, 16'h0003};
      tv[2]  = '{1, 1, 16'h0003, 16'h1111, 1, 16'h0};
      tv[3]  = '{1, 1, 16'h0080, 16'h2222, 1, 16'h0};
      tv[4]  = '{1, 1, 16'd126, 16'hBEEF, 0, 16'h0};
      tv[5]  = '{1, 0, 16'd126, 16'h0,    0, 16'hBEEF};
      tv[6]  = '{1, 0, 16'd2,   16'h0,    0, 16'h1301};
      tv[7]  = '{1, 0, 16'd127, 16'h0,    1, 16'h0};
      tv[8]  = '{1, 1, 16'd8,   16'h5555, 0, 16'h0};
      tv[9]  = '{1, 0, 16'd8,   16'h0,    0, 16'h5555};
      tv[10] = '{0, 1, 16'd6,   16'h7777, 0, 16'hA003};
      tv[11] = '{0, 0, 16'd5,   16'h0,    1, 16'h0};
      tv[12] = '{0, 0, 16'hFFFE, 16'h0,   1, 16'h0};
      if_addr = 0; d_addr = 0; d_wdata = 0;

      // single fetch right after reset
      reset_dut();
      xact(0, 0, 16'd0, 16'h0, rd, er, lat, low);
      check("t1_data", rd, 16'h1201);
      check("t1_err", er, 0);
      check("t1_lat", lat, 2);
      check("t1_nwb", low, 0);

      // both ports held: round-robin on u0, data always on u1
      reset_dut();
      seq = ""; d1cnt = 0; if1cnt = 0;
      d_we = 0; if_addr = 16'd4; d_addr = 16'd2;
      if_req = 1; d_req = 1; if_req1 = 1; d_req1 = 1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (if_ack) seq = {seq, "I"};
         if (d_ack) seq = {seq, "D"};
         if (d_ack1) d1cnt++;
         if (if_ack1) if1cnt++;
      end
      if_req = 0; d_req = 0; if_req1 = 0; d_req1 = 0;
      tick(); tick();
      n_tests++;
      if (seq != "IDID") begin
         n_fail++;
         $display("FAIL rr_order: got %s expected IDID", seq);
      end
      check("rr_if_data", if_rdata, 16'h1421);
      check("rr_d_data", d_rdata, 16'h1301);
      check("prio_d_acks", d1cnt, 4);
      check("prio_if_acks", if1cnt, 0);
      check("prio_d_data", d_rdata1, 16'h1301);

      // table of single transactions
      reset_dut();
      exp_if = 0; exp_d = 0;
      for (int i = 0; i < 13; i++) begin
         xact(tv[i].p, tv[i].we, tv[i].addr, tv[i].wdata, rd, er, lat, low);
         if (!tv[i].err && !(tv[i].p && tv[i].we)) begin
            if (tv[i].p) exp_d = tv[i].rdata; else exp_if = tv[i].rdata;
         end
         check($sformatf("v%0d_err", i), er, tv[i].err);
         check($sformatf("v%0d_lat", i), lat, tv[i].err ? 1 : 2);
         check($sformatf("v%0d_low", i), low, (tv[i].p && tv[i].we && !tv[i].err) ? 1 : 0);
         check($sformatf("v%0d_rdata", i), rd, tv[i].p ? exp_d : exp_if);
      end

      // back-to-back fetches with the request held
      if_req = 1; if_addr = 16'd0; k = 0; prev_c = 0;
      for (int c = 1; c <= 15; c++) begin
         tick();
         if (if_ack && k < 3) begin
            check($sformatf("b2b%0d_data", k), if_rdata, init_word(6'(k)));
            if (k > 0) check($sformatf("b2b%0d_gap", k), c - prev_c, 3);
            prev_c = c; k++;
            if (k == 3) if_req = 0; else if_addr = 16'(2 * k);
         end
      end
      check("b2b_count", k, 3);

      // reset while a store is in ACCESS
      d_req = 1; d_we = 1; d_addr = 16'd10; d_wdata = 16'h1234;
      tick();
      check("rs_nwb_low", mem_r_nWb, 0);
      check("rs_busy", busy, 1);
      rst = 1;
      tick();
      check("rs_nwb", mem_r_nWb, 1);
      check("rs_busy0", busy, 0);
      check("rs_ack", d_ack, 0);
      tick();
      check("rs_hold", {mem_r_nWb, busy, d_ack}, 3'b100);
      d_req = 0; rst = 0; d_we = 0;
      xact(0, 0, 16'd0, 16'h0, rd, er, lat, low);
      check("rs_fetch", rd, 16'h1201);
      xact(1, 0, 16'd10, 16'h0, rd, er, lat, low);
      check("rs_load", rd, init_word(6'd5));

      // random traffic against a shadow memory
      reset_dut();
      for (int i = 0; i < 64; i++) shadow[i] = init_word(6'(i));
      pend[0] = 0; pend[1] = 0; prev_nwb = 1; prev_addr = mem_addr; pwe = 0; pwdata = 0; low_c = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         if (!mem_r_nWb) begin
            low_c++;
            check("wr_guard", {pend[1], pwe, mem_addr == paddr[1], mem_wdata == pwdata}, 4'hF);
         end
         if (!prev_nwb) check("addr_hold", mem_addr, prev_addr);
         prev_nwb = mem_r_nWb; prev_addr = mem_addr;
         for (int p = 0; p < 2; p++) begin
            if (p == 1 ? d_ack : if_ack) begin
               check("ack_pending", pend[p], 1);
               if (pend[p]) begin
                  check("latency", (wait_c[p] + 1) <= 6, 1);
                  check("err", p == 1 ? d_err : if_err, bad_addr(paddr[p]));
                  if (!bad_addr(paddr[p])) begin
                     if (p == 1 && pwe) shadow[paddr[1][6:1]] = pwdata;
                     else check("rdata", p == 1 ? d_rdata : if_rdata, shadow[paddr[p][6:1]]);
                  end
                  if (p == 1) check("store_low", low_c, (pwe && !bad_addr(paddr[1])) ? 1 : 0);
               end
               pend[p] = 0;
               if (cyc < 2950 && $urandom_range(0, 1) == 1) start(p);
               else if (p == 1) d_req = 0; else if_req = 0;
            end else if (pend[p]) begin
               wait_c[p]++;
               if (wait_c[p] > 8) begin
                  check("timeout", wait_c[p], 8);
                  pend[p] = 0;
                  if (p == 1) d_req = 0; else if_req = 0;
               end
            end else if (cyc < 2950 && $urandom_range(0, 2) == 0) start(p);
         end
      end
      check("drained", {pend[0], pend[1], busy}, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
